// File: rtl/wb_pkg.sv
// Shared widths and the buffered-writeback entry type for the writeback arbiter.
package wb_pkg;
    localparam int REG_AW = 5;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] wdata;
    } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Small FIFO holding long-latency writeback results; the head is readable
// combinationally so a pop can write the register file in the same cycle.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   Clk,
    input  logic                   reset,
    input  logic                   push,
    input  wb_entry_t              push_data,
    input  logic                   pop,
    output logic                   full,
    output logic                   empty,
    output wb_entry_t              head,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    wb_entry_t         r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign full      = (r_count == DEPTH_C);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign head      = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge Clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/wb_arbiter.sv
// Register-file write port arbiter: pipeline writeback versus buffered long-latency
// results, with starvation stall. Optional pending-register bitmap under WB_SCOREBOARD_EN.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 8
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              p_we,
    input  logic [REG_AW-1:0] p_rd,
    input  logic [DATA_W-1:0] p_wdata,
    input  logic              l_valid,
    input  logic [REG_AW-1:0] l_rd,
    input  logic [DATA_W-1:0] l_wdata,
    output logic              l_ready,
    output logic              RegWr,
    output logic [REG_AW-1:0] RD,
    output logic [DATA_W-1:0] WData,
    output logic              p_stall
`ifdef WB_SCOREBOARD_EN
    ,
    input  logic              iss_valid,
    input  logic [REG_AW-1:0] iss_rd,
    output logic [31:0]       pend
`endif
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_TOP  = SW'(STARVE_MAX);
    localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_MAX - 1);

    logic                         w_busy;
    logic                         w_pop;
    logic                         w_push;
    logic                         w_full;
    logic                         w_empty;
    logic                         w_fifo_idle;
    wb_entry_t                    w_head;
    wb_entry_t                    w_push_data;
    logic [$clog2(FIFO_DEPTH):0]  w_count;

    logic [SW-1:0]                r_starve;
    logic                         r_stall;
    logic                         r_pop_d;

    assign w_busy      = p_we && (p_rd != '0) && !r_stall;
    assign w_pop       = !reset && !w_busy && !w_empty;
    assign l_ready     = !reset && !w_full;
    assign w_push      = l_valid && l_ready && (l_rd != '0);
    assign w_push_data = '{rd: l_rd, wdata: l_wdata};
    assign w_fifo_idle = (w_count == '0);
    assign p_stall     = r_stall;

    wb_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .Clk      (Clk),
        .reset    (reset),
        .push     (w_push),
        .push_data(w_push_data),
        .pop      (w_pop),
        .full     (w_full),
        .empty    (w_empty),
        .head     (w_head),
        .count    (w_count)
    );

    always_comb begin
        RegWr = 1'b0;
        RD    = '0;
        WData = '0;
        if (!reset) begin
            if (w_busy) begin
                RegWr = 1'b1;
                RD    = p_rd;
                WData = p_wdata;
            end else if (!w_empty) begin
                RegWr = 1'b1;
                RD    = w_head.rd;
                WData = w_head.wdata;
            end
        end
    end

    // The stall drops one edge after the first pop it forces, so a second
    // buffered entry still drains ahead of the held pipeline write.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            r_starve <= '0;
            r_stall  <= 1'b0;
            r_pop_d  <= 1'b0;
        end else begin
            r_pop_d <= w_pop;
            if (w_pop || w_fifo_idle) begin
                r_starve <= '0;
            end else if (r_starve < STARVE_TOP) begin
                r_starve <= r_starve + 1'b1;
            end
            if (r_pop_d) begin
                r_stall <= 1'b0;
            end else if (!w_pop && !w_fifo_idle && (r_starve == STARVE_LAST)) begin
                r_stall <= 1'b1;
            end
        end
    end

`ifdef WB_SCOREBOARD_EN
    logic [31:0] r_pend;
    logic [31:0] w_pend_next;

    always_comb begin
        w_pend_next = r_pend;
        if (w_pop) begin
            w_pend_next[w_head.rd] = 1'b0;
        end
        if (iss_valid && (iss_rd != '0)) begin
            w_pend_next[iss_rd] = 1'b1;
        end
        w_pend_next[0] = 1'b0;
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_next;
        end
    end

    assign pend = r_pend;
`endif
endmodule
